mem_access_unit: RTL and testbench

Memory-stage load/store unit directly downstream of the ALU in the MIPS datapath. It takes the ALU result as the effective address and performs byte/halfword/word accesses over a request/grant/response bus to data memory. It holds the core via `Stall` until each access completes, then returns an aligned, extended `ReadData` to the write-back mux. Misaligned accesses and bus timeouts are flagged without hanging the core.

---
 rtl/mem_access_unit_pkg.sv | 55 +++++
 rtl/mem_access_unit_if.sv | 44 ++++
 rtl/mem_access_unit_load_align.sv | 42 ++++
 rtl/mem_access_unit.sv | 176 +++++++++++++++++
 tb/tb_mem_access_unit.sv | 231 +++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_unit_pkg.sv
// mips_mem_pkg: definitions shared by the memory-stage load/store unit.
//   - lsu_state_t     : access FSM states
//   - SZ_*            : MemSize encodings
//   - BE_*            : byte-enable constants (little-endian lanes)
//   - DEFAULT_TIMEOUT : default bus timeout in cycles (8-bit counter)
//   - is_misaligned() : alignment check for a size/offset pair
//   - store_be()      : byte enables for a size/offset pair
package mips_mem_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_REQ  = 2'b01,
        ST_WAIT = 2'b10,
        ST_DONE = 2'b11
    } lsu_state_t;

    localparam logic [1:0] SZ_BYTE    = 2'b00;
    localparam logic [1:0] SZ_HALF    = 2'b01;
    localparam logic [1:0] SZ_WORD    = 2'b10;
    localparam logic [1:0] SZ_ILLEGAL = 2'b11;

    localparam logic [3:0] BE_NONE    = 4'b0000;
    localparam logic [3:0] BE_BYTE0   = 4'b0001;
    localparam logic [3:0] BE_HALF_LO = 4'b0011;
    localparam logic [3:0] BE_HALF_HI = 4'b1100;
    localparam logic [3:0] BE_WORD    = 4'b1111;

    localparam int DEFAULT_TIMEOUT = 255;
    localparam int TIMEOUT_W       = 8;

    // Halves must sit on even addresses, words on multiples of four;
    // the reserved size code is always rejected.
    function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] offset);
        logic bad;
        case (size)
            SZ_BYTE: bad = 1'b0;
            SZ_HALF: bad = offset[0];
            SZ_WORD: bad = |offset;
            default: bad = 1'b1;
        endcase
        return bad;
    endfunction

    function automatic logic [3:0] store_be(input logic [1:0] size, input logic [1:0] offset);
        logic [3:0] be;
        case (size)
            SZ_BYTE: be = BE_BYTE0 << offset;
            SZ_HALF: be = offset[1] ? BE_HALF_HI : BE_HALF_LO;
            SZ_WORD: be = BE_WORD;
            default: be = BE_NONE;
        endcase
        return be;
    endfunction

endpackage

// File: rtl/mem_access_unit_if.sv
// mem_access_unit_if: request/grant/response bus between the load/store
// unit (master) and data memory (slave).
//   mem_req    master->slave  request, held until mem_gnt
//   mem_we     master->slave  write enable
//   mem_addr   master->slave  word-aligned byte address
//   mem_wdata  master->slave  lane-replicated store data
//   mem_be     master->slave  byte enables, little-endian
//   mem_gnt    slave->master  request accepted this cycle
//   mem_rvalid slave->master  read data valid
//   mem_rdata  slave->master  read word
interface mem_access_unit_if;

    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_gnt;
    logic        mem_rvalid;
    logic [31:0] mem_rdata;

    modport master (
        output mem_req,
        output mem_we,
        output mem_addr,
        output mem_wdata,
        output mem_be,
        input  mem_gnt,
        input  mem_rvalid,
        input  mem_rdata
    );

    modport slave (
        input  mem_req,
        input  mem_we,
        input  mem_addr,
        input  mem_wdata,
        input  mem_be,
        output mem_gnt,
        output mem_rvalid,
        output mem_rdata
    );

endinterface

// File: rtl/mem_access_unit_load_align.sv
// lsu_load_align: combinational load lane select and extension.
//   rdata         in  32  raw word from memory
//   offset        in  2   byte offset of the access within the word
//   size          in  2   SZ_BYTE / SZ_HALF / SZ_WORD
//   load_unsigned in  1   1 = zero-extend, 0 = sign-extend
//   read_data     out 32  aligned, extended result
module lsu_load_align
    import mips_mem_pkg::*;
(
    input  logic [31:0] rdata,
    input  logic [1:0]  offset,
    input  logic [1:0]  size,
    input  logic        load_unsigned,
    output logic [31:0] read_data
);

    logic [7:0]  byte_lane [4];
    logic [7:0]  sel_byte;
    logic [15:0] sel_half;
    logic        byte_sign;
    logic        half_sign;

    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_byte_lane
            assign byte_lane[gi] = rdata[8*gi +: 8];
        end
    endgenerate

    always_comb begin
        sel_byte  = byte_lane[offset];
        sel_half  = offset[1] ? rdata[31:16] : rdata[15:0];
        byte_sign = ~load_unsigned & sel_byte[7];
        half_sign = ~load_unsigned & sel_half[15];
        case (size)
            SZ_BYTE: read_data = {{24{byte_sign}}, sel_byte};
            SZ_HALF: read_data = {{16{half_sign}}, sel_half};
            default: read_data = rdata;
        endcase
    end

endmodule

// File: rtl/mem_access_unit.sv
// mem_access_unit: memory-stage load/store unit of the MIPS datapath.
// Uses the ALU result as the effective byte address, issues one
// byte/half/word access over the request/grant/response bus, stalls the
// core until it completes and returns aligned, extended load data.
//   clk, reset         clock and synchronous active-high reset
//   ALUResult          effective byte address
//   WriteData          store data (rt)
//   MemRead, MemWrite  access request (MemWrite wins when both are set)
//   MemSize            SZ_BYTE / SZ_HALF / SZ_WORD (11 is illegal)
//   LoadUnsigned       zero- (1) or sign- (0) extend sub-word loads
//   ReadData           load result, valid in the DONE cycle
//   Stall              freeze PC and pipeline registers
//   MisalignErr        misaligned/illegal access, nothing issued
//   BusErr             one-cycle pulse in DONE after a bus timeout
//   bus                master side of the memory bus
module mem_access_unit
    import mips_mem_pkg::*;
#(
    // Must be in 1..255: the counter is TIMEOUT_W bits wide.
    parameter int TIMEOUT = DEFAULT_TIMEOUT
)
(
    input  logic               clk,
    input  logic               reset,
    input  logic [31:0]        ALUResult,
    input  logic [31:0]        WriteData,
    input  logic               MemRead,
    input  logic               MemWrite,
    input  logic [1:0]         MemSize,
    input  logic               LoadUnsigned,
    output logic [31:0]        ReadData,
    output logic               Stall,
    output logic               MisalignErr,
    output logic               BusErr,
    mem_access_unit_if.master  bus
);

    // The access is abandoned in the cycle the counter would reach TIMEOUT,
    // so REQ+WAIT never spans more than TIMEOUT cycles.
    localparam logic [TIMEOUT_W-1:0] TIMEOUT_LAST = TIMEOUT_W'(TIMEOUT - 1);

    lsu_state_t           state_reg;
    logic                 mem_req_reg;
    logic                 mem_we_reg;
    logic [31:0]          mem_addr_reg;
    logic [31:0]          mem_wdata_reg;
    logic [3:0]           mem_be_reg;
    logic [31:0]          read_data_reg;
    logic                 bus_err_reg;
    logic [TIMEOUT_W-1:0] cnt_reg;
    logic [1:0]           offset_reg;
    logic [1:0]           size_reg;
    logic                 unsigned_reg;

    logic                 request;
    logic                 misaligned;
    logic                 launch;
    logic                 timeout_hit;
    logic [TIMEOUT_W-1:0] cnt_inc;
    logic [31:0]          lane_data;
    logic [31:0]          load_data;

    assign request     = MemRead | MemWrite;
    assign misaligned  = is_misaligned(MemSize, ALUResult[1:0]);
    assign launch      = (state_reg == ST_IDLE) && request && !misaligned;
    assign MisalignErr = (state_reg == ST_IDLE) && request && misaligned;
    // The launch cycle stalls combinationally so the core holds the
    // instruction while the request is being registered.
    assign Stall       = launch || (state_reg == ST_REQ) || (state_reg == ST_WAIT);
    assign cnt_inc     = cnt_reg + 1'b1;
    // The counter never exceeds TIMEOUT, so >= cannot be fooled by a wrap;
    // it also covers a grant on the last REQ cycle followed by WAIT.
    assign timeout_hit = (cnt_reg >= TIMEOUT_LAST);

    // Store lane replication: each byte lane picks the byte of WriteData
    // that belongs there for the current size, so the byte enables alone
    // decide which lanes memory actually writes.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_store_lane
            localparam int HALF_SEL = gi % 2;
            assign lane_data[8*gi +: 8] =
                (MemSize == SZ_BYTE) ? WriteData[7:0] :
                (MemSize == SZ_HALF) ? WriteData[8*HALF_SEL +: 8] :
                                       WriteData[8*gi +: 8];
        end
    endgenerate

    lsu_load_align u_load_align (
        .rdata         (bus.mem_rdata),
        .offset        (offset_reg),
        .size          (size_reg),
        .load_unsigned (unsigned_reg),
        .read_data     (load_data)
    );

    always_ff @(posedge clk) begin
        if (reset) begin
            state_reg     <= ST_IDLE;
            mem_req_reg   <= 1'b0;
            mem_we_reg    <= 1'b0;
            mem_addr_reg  <= '0;
            mem_wdata_reg <= '0;
            mem_be_reg    <= '0;
            read_data_reg <= '0;
            bus_err_reg   <= 1'b0;
            cnt_reg       <= '0;
            offset_reg    <= '0;
            size_reg      <= SZ_BYTE;
            unsigned_reg  <= 1'b0;
        end else begin
            bus_err_reg <= 1'b0;
            case (state_reg)
                ST_IDLE: begin
                    if (launch) begin
                        state_reg     <= ST_REQ;
                        mem_req_reg   <= 1'b1;
                        mem_we_reg    <= MemWrite;
                        mem_addr_reg  <= {ALUResult[31:2], 2'b00};
                        mem_wdata_reg <= lane_data;
                        mem_be_reg    <= store_be(MemSize, ALUResult[1:0]);
                        offset_reg    <= ALUResult[1:0];
                        size_reg      <= MemSize;
                        unsigned_reg  <= LoadUnsigned;
                        cnt_reg       <= '0;
                    end
                end
                ST_REQ: begin
                    cnt_reg <= cnt_inc;
                    if (bus.mem_gnt) begin
                        mem_req_reg <= 1'b0;
                        if (mem_we_reg) begin
                            state_reg     <= ST_DONE;
                            read_data_reg <= '0;
                        end else begin
                            state_reg <= ST_WAIT;
                        end
                    end else if (timeout_hit) begin
                        mem_req_reg   <= 1'b0;
                        state_reg     <= ST_DONE;
                        read_data_reg <= '0;
                        bus_err_reg   <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    cnt_reg <= cnt_inc;
                    if (bus.mem_rvalid) begin
                        state_reg     <= ST_DONE;
                        read_data_reg <= load_data;
                    end else if (timeout_hit) begin
                        state_reg     <= ST_DONE;
                        read_data_reg <= '0;
                        bus_err_reg   <= 1'b1;
                    end
                end
                ST_DONE: begin
                    // The core commits this cycle; the next instruction is
                    // evaluated afresh in IDLE.
                    state_reg <= ST_IDLE;
                end
                default: begin
                    state_reg <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.mem_req   = mem_req_reg;
    assign bus.mem_we    = mem_we_reg;
    assign bus.mem_addr  = mem_addr_reg;
    assign bus.mem_wdata = mem_wdata_reg;
    assign bus.mem_be    = mem_be_reg;
    assign ReadData      = read_data_reg;
    assign BusErr        = bus_err_reg;

endmodule

// File: tb/tb_mem_access_unit.sv
// Self-checking bench for mem_access_unit. The bench plays data memory;
// each access pushes its expected bus request and result onto a
// scoreboard that is checked at grant time and in the DONE cycle.
module tb_mem_access_unit;
    import mips_mem_pkg::*;

    typedef struct {
        logic [31:0] addr;
        logic [3:0]  be;
        logic [31:0] wdata;
        logic        we;
        logic [31:0] rdata;
        logic        bus_err;
        int          stalls;
    } exp_t;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] ALUResult;
    logic [31:0] WriteData;
    logic        MemRead;
    logic        MemWrite;
    logic [1:0]  MemSize;
    logic        LoadUnsigned;
    logic [31:0] ReadData;
    logic        Stall;
    logic        MisalignErr;
    logic        BusErr;

    int   n_vec = 0;
    int   n_err = 0;
    exp_t sb_q[$];

    mem_access_unit_if bus();

    mem_access_unit #(.TIMEOUT(255)) dut (
        .clk          (clk),
        .reset        (reset),
        .ALUResult    (ALUResult),
        .WriteData    (WriteData),
        .MemRead      (MemRead),
        .MemWrite     (MemWrite),
        .MemSize      (MemSize),
        .LoadUnsigned (LoadUnsigned),
        .ReadData     (ReadData),
        .Stall        (Stall),
        .MisalignErr  (MisalignErr),
        .BusErr       (BusErr),
        .bus          (bus)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // One complete access. Inputs are driven just after a rising edge,
    // outputs are sampled and memory responses set up on falling edges.
    task automatic run_access(
        input logic        rd, input logic wr, input logic [1:0] sz, input logic uns,
        input logic [31:0] addr, input logic [31:0] wd,
        input int          gnt_wait, input int rv_wait, input logic [31:0] word,
        input logic        spurious,
        input logic [31:0] x_addr, input logic [3:0] x_be, input logic [31:0] x_wdata,
        input logic        x_we, input logic [31:0] x_rdata, input logic x_berr,
        input int          x_stalls);
        exp_t e;
        exp_t got_e;
        int   stalls = 0;
        int   req_cyc = 0;
        int   wait_cyc = 0;
        int   berr_seen = 0;
        bit   granted = 0;
        bit   rv_given = 0;
        bit   done = 0;
        e = '{addr: x_addr, be: x_be, wdata: x_wdata, we: x_we,
              rdata: x_rdata, bus_err: x_berr, stalls: x_stalls};
        sb_q.push_back(e);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; MemSize = sz; LoadUnsigned = uns;
        ALUResult = addr; WriteData = wd;
        for (int c = 0; c < 600 && !done; c++) begin
            @(negedge clk);
            if (c == 0) check_eq("misalign_clear", MisalignErr, 0);
            if (BusErr) berr_seen++;
            if (Stall) begin
                stalls++;
            end else begin
                got_e = sb_q.pop_front();
                check_eq("read_data", ReadData, got_e.rdata);
                check_eq("bus_err_done", BusErr, got_e.bus_err);
                check_eq("stall_cycles", stalls, got_e.stalls);
                check_eq("req_low_done", bus.mem_req, 0);
                done = 1;
                MemRead = 0; MemWrite = 0;
            end
            if (!done) begin
                bus.mem_gnt = 0;
                bus.mem_rvalid = 0;
                if (bus.mem_req) begin
                    if (req_cyc == gnt_wait) begin
                        check_eq("req_addr", bus.mem_addr, sb_q[0].addr);
                        check_eq("req_we", bus.mem_we, sb_q[0].we);
                        if (sb_q[0].we) begin
                            check_eq("req_be", bus.mem_be, sb_q[0].be);
                            check_eq("req_wdata", bus.mem_wdata, sb_q[0].wdata);
                        end
                        bus.mem_gnt = 1;
                    end else if (spurious) begin
                        bus.mem_rvalid = 1;
                        bus.mem_rdata = 32'hBAD0_BAD0;
                    end
                    req_cyc++;
                end else if (granted && !rv_given) begin
                    if (wait_cyc == rv_wait) begin
                        bus.mem_rvalid = 1;
                        bus.mem_rdata = word;
                        rv_given = 1;
                    end else begin
                        wait_cyc++;
                    end
                end
                if (bus.mem_gnt) granted = 1;
            end
        end
        bus.mem_gnt = 0;
        bus.mem_rvalid = 0;
        check_eq("done_seen", done, 1);
        if (!done) begin
            MemRead = 0; MemWrite = 0;
            if (sb_q.size() > 0) void'(sb_q.pop_front());
        end
        check_eq("bus_err_pulses", berr_seen, x_berr);
        $display("access rd=%0b wr=%0b size=%0d addr=%h stalls=%0d read_data=%h", rd, wr, sz, addr, stalls, ReadData);
    endtask

    task automatic run_misalign(input logic rd, input logic wr, input logic [1:0] sz, input logic [31:0] addr);
        @(posedge clk); #1;
        MemRead = rd; MemWrite = wr; MemSize = sz; LoadUnsigned = 0;
        ALUResult = addr; WriteData = 32'h1111_2222;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            check_eq("misalign_err", MisalignErr, 1);
            check_eq("misalign_stall", Stall, 0);
            check_eq("misalign_req", bus.mem_req, 0);
        end
        MemRead = 0; MemWrite = 0;
        #1;
        check_eq("misalign_idle", MisalignErr, 0);
        $display("misalign size=%0d addr=%h err=%0b", sz, addr, MisalignErr);
    endtask

    initial begin
        reset = 1; MemRead = 0; MemWrite = 0; MemSize = SZ_WORD; LoadUnsigned = 0;
        ALUResult = 0; WriteData = 0;
        bus.mem_gnt = 0; bus.mem_rvalid = 0; bus.mem_rdata = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check_eq("rst_req", bus.mem_req, 0);
        check_eq("rst_we", bus.mem_we, 0);
        check_eq("rst_addr", bus.mem_addr, 0);
        check_eq("rst_wdata", bus.mem_wdata, 0);
        check_eq("rst_be", bus.mem_be, 0);
        check_eq("rst_read_data", ReadData, 0);
        check_eq("rst_bus_err", BusErr, 0);
        check_eq("rst_stall", Stall, 0);
        reset = 0;

        //          rd wr size    uns addr          wdata         gw rw word          sp  x_addr        x_be     x_wdata       we x_rdata       be st
        run_access(1, 0, SZ_BYTE, 0, 32'h102,      32'h0,        0, 0, 32'h0080FF00, 0, 32'h100,      4'b0000, 32'h0,        0, 32'hFFFFFF80, 0, 3);
        run_access(0, 1, SZ_WORD, 0, 32'h100,      32'hDEADBEEF, 0, 0, 32'h0,        0, 32'h100,      4'b1111, 32'hDEADBEEF, 1, 32'h0,        0, 2);
        run_access(1, 0, SZ_BYTE, 1, 32'h102,      32'h0,        0, 0, 32'h0080FF00, 0, 32'h100,      4'b0000, 32'h0,        0, 32'h00000080, 0, 3);
        run_access(0, 1, SZ_BYTE, 0, 32'h103,      32'h000000A5, 0, 0, 32'h0,        0, 32'h100,      4'b1000, 32'hA5A5A5A5, 1, 32'h0,        0, 2);
        run_access(0, 1, SZ_HALF, 0, 32'h102,      32'h1234BEEF, 2, 0, 32'h0,        0, 32'h100,      4'b1100, 32'hBEEFBEEF, 1, 32'h0,        0, 4);
        run_access(1, 1, SZ_BYTE, 0, 32'h011,      32'h0000005C, 1, 0, 32'h0,        0, 32'h010,      4'b0010, 32'h5C5C5C5C, 1, 32'h0,        0, 3);
        run_access(1, 0, SZ_HALF, 0, 32'h206,      32'h0,        0, 3, 32'h80017FFF, 0, 32'h204,      4'b0000, 32'h0,        0, 32'hFFFF8001, 0, 6);
        run_access(1, 0, SZ_HALF, 1, 32'h204,      32'h0,        0, 0, 32'h8001F00D, 0, 32'h204,      4'b0000, 32'h0,        0, 32'h0000F00D, 0, 3);
        run_access(1, 0, SZ_BYTE, 0, 32'h301,      32'h0,        0, 0, 32'h00007F00, 0, 32'h300,      4'b0000, 32'h0,        0, 32'h0000007F, 0, 3);
        run_access(1, 0, SZ_WORD, 0, 32'h300,      32'h0,        1, 0, 32'h12345678, 1, 32'h300,      4'b0000, 32'h0,        0, 32'h12345678, 0, 4);

        // Reset while waiting for read data abandons the access.
        @(posedge clk); #1;
        MemRead = 1; MemWrite = 0; MemSize = SZ_WORD; LoadUnsigned = 0;
        ALUResult = 32'h600; WriteData = 32'hCAFEF00D;
        @(negedge clk);
        check_eq("rwait_launch_stall", Stall, 1);
        @(negedge clk);
        check_eq("rwait_req", bus.mem_req, 1);
        bus.mem_gnt = 1;
        @(negedge clk);
        bus.mem_gnt = 0;
        check_eq("rwait_stall", Stall, 1);
        check_eq("rwait_req_low", bus.mem_req, 0);
        reset = 1; MemRead = 0;
        @(negedge clk);
        check_eq("mid_rst_req", bus.mem_req, 0);
        check_eq("mid_rst_we", bus.mem_we, 0);
        check_eq("mid_rst_addr", bus.mem_addr, 0);
        check_eq("mid_rst_wdata", bus.mem_wdata, 0);
        check_eq("mid_rst_be", bus.mem_be, 0);
        check_eq("mid_rst_read_data", ReadData, 0);
        check_eq("mid_rst_bus_err", BusErr, 0);
        check_eq("mid_rst_stall", Stall, 0);
        reset = 0;
        for (int c = 0; c < 2; c++) begin
            @(negedge clk);
            check_eq("post_rst_stall", Stall, 0);
            check_eq("post_rst_req", bus.mem_req, 0);
        end
        $display("reset during WAIT: req=%0b read_data=%h", bus.mem_req, ReadData);

        run_access(1, 0, SZ_WORD, 0, 32'h600,      32'h0,        0, 1, 32'hA5A55A5A, 0, 32'h600,      4'b0000, 32'h0,        0, 32'hA5A55A5A, 0, 4);
        // Grant withheld: 255 REQ cycles plus the launch cycle, then BusErr.
        run_access(1, 0, SZ_WORD, 0, 32'h400,      32'h0,     1000, 0, 32'h0,        1, 32'h400,      4'b0000, 32'h0,        0, 32'h0,        1, 256);

        run_misalign(1, 0, SZ_HALF,    32'h101);
        run_misalign(1, 0, SZ_WORD,    32'h102);
        run_misalign(0, 1, SZ_ILLEGAL, 32'h100);

        run_access(1, 0, SZ_BYTE, 1, 32'h7F3,      32'h0,        0, 0, 32'h9A000000, 0, 32'h7F0,      4'b0000, 32'h0,        0, 32'h0000009A, 0, 3);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
